led_pattern_ctrl: RTL and testbench
===================================

LED_PATTERN_CTRL -- requirements
Module: led_pattern_ctrl

Interface
REQ-001 SHALL have parameter LED_W, default 4: number of LED outputs, legal range 2..32.
REQ-002 SHALL have parameter DEB_CYCLES, default 50000: consecutive stable cycles needed to accept a pushbutton level change, legal minimum 1.
REQ-003 SHALL have parameter TICK_DIV, default 12500000: clk cycles per pattern step, legal minimum 2.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port pb, input, 2 bits: raw asynchronous pushbuttons, active-high; pb[0] = next mode, pb[1] = return to SOLID.
REQ-007 SHALL have port dip, input, 1 bit: raw asynchronous enable switch, active-high.
REQ-008 SHALL have port LED, output, LED_W bits: registered LED drive, active-high.
REQ-009 SHALL have port mode, output, 2 bits: registered current state, encoded OFF=0, SOLID=1, BLINK=2, SHIFT=3.

Function
REQ-010 SHALL pass pb[1:0] and dip each through a 2-flop synchroniser before any other use.
REQ-011 SHALL debounce each synchronised pb bit independently with its own counter.
- Debounced level flips on the DEB_CYCLES-th consecutive cycle the synchronised input differs from it.
- Any cycle of agreement clears that counter.
REQ-012 SHALL generate a one-cycle press pulse on each debounced 0->1 transition; releases generate nothing.
REQ-013 SHALL implement FSM states OFF, SOLID, BLINK, SHIFT.
- Any state, synchronised dip=0 -> OFF.
- OFF with synchronised dip=1 -> SOLID.
- SOLID/BLINK/SHIFT with pb[0] press -> next state in the cycle SOLID->BLINK->SHIFT->SOLID.
- SOLID/BLINK/SHIFT with pb[1] press -> SOLID.
REQ-014 SHALL give priority dip=0 > pb[1] press > pb[0] press when they coincide in one cycle.
REQ-015 SHALL ignore presses while in OFF; presses are not queued.
REQ-016 SHALL run a tick counter 0..TICK_DIV-1 that emits a one-cycle tick at TICK_DIV-1 and then wraps to 0.
- Counter is forced to 0 in any cycle in which the state changes.
- Counter is held at 0 while in OFF.
REQ-017 SHALL update LED one cycle after the state/tick that causes the change:
- OFF: all 0.
- SOLID: all 1.
- BLINK: all 1 on entry, bitwise inverted on each tick.
- SHIFT: one-hot bit 0 on entry, rotated left by one on each tick, MSB wrapping to bit 0.
REQ-018 SHALL keep LED one-hot at every cycle while in SHIFT, for every LED_W.
REQ-019 SHALL produce, for a clean pb[0] press starting at cycle 0, a mode change at cycle 2+DEB_CYCLES+1 and a LED change one cycle later.

Reset
REQ-020 SHALL, while rst_n=0, immediately force: LED=0, mode=OFF (0), synchroniser flops=0, debounced levels=0, debounce counters=0, tick counter=0.
REQ-021 SHALL, on rst_n release with dip held 1, reach SOLID after the 2-cycle dip synchroniser latency plus one FSM cycle.
REQ-022 SHALL, on reset asserted mid-pattern, discard all pattern phase; after release the pattern restarts from its entry value.
REQ-023 SHALL not generate a press pulse from a button already held at rst_n release until that button is debounced high from the reset level 0.

Configuration
REQ-024 SHALL support macro LED_PATTERN_BOUNCE_EN to select SHIFT behaviour:
- Defined: SHIFT ping-pongs. Direction reverses on the tick that would move past bit LED_W-1 or bit 0. Direction resets to left on every SHIFT entry.
- Undefined: SHIFT wraps per REQ-017 and no direction register exists.

Verification (bench uses DEB_CYCLES=4, TICK_DIV=8, LED_W=4)
REQ-025 SHALL cover: reset, dip=1, release rst_n -> mode=1 and LED=4'b1111 within 4 cycles.
REQ-026 SHALL cover: pb[0] bounce 1,0,1,0 every cycle, then held 1 -> exactly one transition SOLID->BLINK; LED toggles 1111/0000 every 8 cycles.
REQ-027 SHALL cover: two further clean pb[0] presses -> SHIFT with LED 0001,0010,0100,1000,0001 on successive ticks, then SOLID.
REQ-028 SHALL cover: with LED_PATTERN_BOUNCE_EN defined, SHIFT -> LED 0001,0010,0100,1000,0100,0010,0001,0010.
REQ-029 SHALL cover: pb[0] and pb[1] debounced in the same cycle while in BLINK -> SOLID; dip=0 in the same cycle as a press -> OFF, LED=0000.
REQ-030 SHALL cover: rst_n pulsed low mid-SHIFT with dip=1 -> LED=0000 immediately, then SOLID, and a held pb[0] yields one press only after 4 stable cycles.

Source files
------------

// File: rtl/led_pattern_ctrl.sv
// LED pattern controller: synchronised/debounced buttons drive an OFF/SOLID/BLINK/SHIFT FSM.
// Define LED_PATTERN_BOUNCE_EN to make SHIFT ping-pong instead of wrapping.
module led_pattern_ctrl #(
  parameter int LED_W      = 4,
  parameter int DEB_CYCLES = 50000,
  parameter int TICK_DIV   = 12500000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       pb,
  input  logic             dip,
  output logic [LED_W-1:0] LED,
  output logic [1:0]       mode
);

  localparam logic [1:0] ST_OFF   = 2'd0;
  localparam logic [1:0] ST_SOLID = 2'd1;
  localparam logic [1:0] ST_BLINK = 2'd2;
  localparam logic [1:0] ST_SHIFT = 2'd3;

  localparam int DEB_W  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int TICK_W = $clog2(TICK_DIV);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [LED_W-1:0]  LED_ONE   = LED_W'(1);

  // bit 2 = dip, bits 1:0 = pb
  logic [2:0] r_sync1;
  logic [2:0] r_sync2;
  logic       w_dip;
  logic [1:0] w_press;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= {dip, pb};
      r_sync2 <= r_sync1;
    end
  end

  assign w_dip = r_sync2[2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_deb
      logic [DEB_W-1:0] r_cnt;
      logic             r_lvl;
      logic             r_press;

      // r_press marks the cycle right after the debounced level rises
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_cnt   <= '0;
          r_lvl   <= 1'b0;
          r_press <= 1'b0;
        end else begin
          r_press <= 1'b0;
          if (r_sync2[gi] == r_lvl) begin
            r_cnt <= '0;
          end else if (r_cnt == DEB_LAST) begin
            r_cnt   <= '0;
            r_lvl   <= ~r_lvl;
            r_press <= ~r_lvl;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
      end

      assign w_press[gi] = r_press;
    end
  endgenerate

  logic [1:0]        r_state;
  logic [1:0]        w_state_next;
  logic [TICK_W-1:0] r_tick_cnt;
  logic              w_tick;

  always_comb begin
    w_state_next = r_state;
    if (!w_dip) begin
      w_state_next = ST_OFF;
    end else if (r_state == ST_OFF) begin
      w_state_next = ST_SOLID;
    end else if (w_press[1]) begin
      w_state_next = ST_SOLID;
    end else if (w_press[0]) begin
      case (r_state)
        ST_SOLID: w_state_next = ST_BLINK;
        ST_BLINK: w_state_next = ST_SHIFT;
        default:  w_state_next = ST_SOLID;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_OFF;
    end else begin
      r_state <= w_state_next;
    end
  end

  assign w_tick = (r_tick_cnt == TICK_LAST) && (r_state != ST_OFF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick_cnt <= '0;
    end else if ((w_state_next != r_state) || (r_state == ST_OFF) || (r_tick_cnt == TICK_LAST)) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end

  // r_led_state is the state the LEDs last reflected; a mismatch means a fresh entry
  logic [1:0]       r_led_state;
  logic [LED_W-1:0] r_led;
  logic             w_entry;

  assign w_entry = (r_state != r_led_state);

`ifdef LED_PATTERN_BOUNCE_EN
  logic r_dir_right;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_led_state <= ST_OFF;
      r_led       <= '0;
      r_dir_right <= 1'b0;
    end else begin
      r_led_state <= r_state;
      case (r_state)
        ST_SOLID: r_led <= '1;
        ST_BLINK: begin
          if (w_entry)     r_led <= '1;
          else if (w_tick) r_led <= ~r_led;
        end
        ST_SHIFT: begin
          if (w_entry) begin
            r_led       <= LED_ONE;
            r_dir_right <= 1'b0;
          end else if (w_tick) begin
            if (!r_dir_right) begin
              if (r_led[LED_W-1]) begin
                r_dir_right <= 1'b1;
                r_led       <= r_led >> 1;
              end else begin
                r_led <= r_led << 1;
              end
            end else begin
              if (r_led[0]) begin
                r_dir_right <= 1'b0;
                r_led       <= r_led << 1;
              end else begin
                r_led <= r_led >> 1;
              end
            end
          end
        end
        default: r_led <= '0;
      endcase
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_led_state <= ST_OFF;
      r_led       <= '0;
    end else begin
      r_led_state <= r_state;
      case (r_state)
        ST_SOLID: r_led <= '1;
        ST_BLINK: begin
          if (w_entry)     r_led <= '1;
          else if (w_tick) r_led <= ~r_led;
        end
        ST_SHIFT: begin
          if (w_entry)     r_led <= LED_ONE;
          else if (w_tick) r_led <= {r_led[LED_W-2:0], r_led[LED_W-1]};
        end
        default: r_led <= '0;
      endcase
    end
  end
`endif

  assign LED  = r_led;
  assign mode = r_state;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Bench for led_pattern_ctrl: directed scenarios plus random button/dip traffic,
// every cycle compared against a window/age based reference model.
module tb_led_pattern_ctrl;
  localparam int W    = 4;
  localparam int DEB  = 4;
  localparam int TDIV = 8;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic [1:0]   pb    = 2'b00;
  logic         dip   = 1'b0;
  logic [W-1:0] LED;
  logic [1:0]   mode;

  always #5 clk = ~clk;

  led_pattern_ctrl #(.LED_W(W), .DEB_CYCLES(DEB), .TICK_DIV(TDIV)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .pb   (pb),
    .dip  (dip),
    .LED  (LED),
    .mode (mode)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
  endtask

  // Reference model: raw inputs are seen two edges late, a button level flips once
  // the last DEB seen samples all disagree with it, LEDs are a function of state and
  // the number of whole tick periods spent in it.
  logic [2:0]     m_dly0, m_dly1;
  logic [DEB-1:0] m_win [2];
  logic [1:0]     m_lvl, m_press;
  int             m_state, m_age;
  logic [W-1:0]   m_led;

  function automatic logic [W-1:0] pattern(input int st, input int n);
    logic [W-1:0] one;
    int p;
    one = 1;
    case (st)
      1: return '1;
      2: return (n % 2 == 1) ? '0 : '1;
      3: begin
`ifdef LED_PATTERN_BOUNCE_EN
        p = n % (2 * (W - 1));
        if (p >= W) p = 2 * (W - 1) - p;
`else
        p = n % W;
`endif
        return one << p;
      end
      default: return '0;
    endcase
  endfunction

  task automatic model_reset();
    m_dly0 = '0; m_dly1 = '0;
    m_win[0] = '0; m_win[1] = '0;
    m_lvl = '0; m_press = '0;
    m_state = 0; m_age = 0; m_led = '0;
  endtask

  task automatic model_step();
    logic [2:0] seen;
    logic [1:0] pr;
    int nxt;
    seen = m_dly1;
    if (!seen[2])        nxt = 0;
    else if (m_state==0) nxt = 1;
    else if (m_press[1]) nxt = 1;
    else if (m_press[0]) nxt = m_state % 3 + 1;
    else                 nxt = m_state;
    m_led   = pattern(m_state, (m_age + 1) / TDIV);
    m_age   = (nxt != m_state) ? 0 : m_age + 1;
    m_state = nxt;
    pr = '0;
    for (int b = 0; b < 2; b++) begin
      m_win[b] = {m_win[b][DEB-2:0], seen[b]};
      if (m_win[b] == {DEB{~m_lvl[b]}}) begin
        pr[b]    = ~m_lvl[b];
        m_lvl[b] = ~m_lvl[b];
      end
    end
    m_press = pr;
    m_dly1  = m_dly0;
    m_dly0  = {dip, pb};
  endtask

  task automatic tick_cycle();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    cyc++;
    check("mode", {30'd0, mode}, m_state);
    check("led", {28'd0, LED}, {28'd0, m_led});
  endtask

  task automatic run(input int n);
    repeat (n) tick_cycle();
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_led", {28'd0, LED}, 32'd0);
    check("rst_mode", {30'd0, mode}, 32'd0);
    run(n);
    rst_n = 1'b1;
  endtask

  task automatic wait_model_state(input int st, input int limit, input string tag);
    int k;
    k = 0;
    while (m_state != st && k < limit) begin
      tick_cycle();
      k++;
    end
    check(tag, {30'd0, mode}, st);
  endtask

  logic [W-1:0] shift_tab [8];
  int trans_cnt;
  logic [1:0] prev_mode;

  initial begin
`ifdef LED_PATTERN_BOUNCE_EN
    shift_tab = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
`else
    shift_tab = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
`endif
    #2;
    dip = 1'b1;
    $display("txn reset with dip=1");
    do_reset(3);
    run(4);
    check("power_up_mode", {30'd0, mode}, 32'd1);
    check("power_up_led", {28'd0, LED}, 32'hF);

    $display("txn bouncing pb0 then held");
    trans_cnt = 0;
    prev_mode = mode;
    for (int i = 0; i < 20; i++) begin
      pb[0] = (i < 4) ? ((i % 2) == 0) : (i < 14);
      tick_cycle();
      if (prev_mode == 2'd1 && mode == 2'd2) trans_cnt++;
      prev_mode = mode;
    end
    check("bounce_one_trans", trans_cnt, 32'd1);
    check("bounce_blink", {30'd0, mode}, 32'd2);
    run(20);

    $display("txn pb0 press into SHIFT, pattern walk");
    pb[0] = 1'b1;
    wait_model_state(3, 20, "enter_shift");
    pb[0] = 1'b0;
    tick_cycle();
    for (int k = 0; k < 8; k++) begin
      if (k > 0) run(TDIV);
      check($sformatf("shift_step%0d", k), {28'd0, LED}, {28'd0, shift_tab[k]});
    end
    $display("txn pb0 press back to SOLID");
    pb[0] = 1'b1;
    wait_model_state(1, 20, "shift_to_solid");
    pb[0] = 1'b0;
    run(8);

    $display("txn BLINK with both buttons together");
    pb[0] = 1'b1; run(8); pb[0] = 1'b0; run(8);
    check("blink_again", {30'd0, mode}, 32'd2);
    pb = 2'b11; run(10);
    check("both_to_solid", {30'd0, mode}, 32'd1);
    pb = 2'b00; run(8);

    $display("txn dip drop coinciding with press");
    pb[0] = 1'b1; run(4);
    dip = 1'b0; run(4);
    check("dip_off_mode", {30'd0, mode}, 32'd0);
    check("dip_off_led", {28'd0, LED}, 32'd0);
    pb[0] = 1'b0; dip = 1'b1; run(10);

    $display("txn reset mid SHIFT with pb0 held");
    pb[0] = 1'b1; run(8); pb[0] = 1'b0; run(8);
    pb[0] = 1'b1; run(8); pb[0] = 1'b0; run(12);
    check("shift_before_rst", {30'd0, mode}, 32'd3);
    pb[0] = 1'b1; run(2);
    do_reset(2);
    run(6);
    check("held_no_early_press", {30'd0, mode}, 32'd1);
    run(1);
    check("held_press_after_deb", {30'd0, mode}, 32'd2);
    pb[0] = 1'b0; run(8);

    for (int s = 0; s < 200; s++) begin
      int len;
      bit bouncy;
      len    = $urandom_range(1, 14);
      bouncy = ($urandom_range(0, 5) == 0);
      pb     = 2'($urandom_range(0, 3));
      dip    = ($urandom_range(0, 7) != 0);
      $display("txn rand %0d pb=%b dip=%b len=%0d bouncy=%0d", s, pb, dip, len, bouncy);
      if ($urandom_range(0, 39) == 0) do_reset($urandom_range(1, 3));
      for (int i = 0; i < len; i++) begin
        if (bouncy) pb = pb ^ 2'($urandom_range(0, 3));
        tick_cycle();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
